// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, HALT opcode and the
// opcode-field position that the decoder also uses.
package fetch_pkg;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    WAIT,
    DRAIN,
    HOLD,
    HALTED
  } fetchState_t;

  localparam logic [10:0] HALT_OPCODE = 11'b11111111111;
  localparam int unsigned PC_STEP     = 4;
  localparam int unsigned OPCODE_MSB  = 31;
  localparam int unsigned OPCODE_LSB  = 21;

  // True when the instruction word carries the HALT opcode.
  function automatic logic isHaltInstr(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// LEGv8 fetch stage: owns the PC, issues one outstanding instruction-memory
// read at a time and hands each word to decode over a valid/ready handshake.
// Branch redirects from execute restart fetch; decode accepting HALT stops it
// until reset.
// Optional build macro FETCH_PERF_EN adds a saturating accepted-instruction
// counter output fetch_count.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH    = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [PC_WIDTH-1:0]    if_pc,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  output logic                   halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]            fetch_count
`endif
);

  fetchState_t         state;
  fetchState_t         stateNext;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pcNext;
  logic                reqValidNext;
  logic                ifValidNext;
  logic                haltedNext;
  logic                loadInstr;
  logic                decodeAccept;
  logic                heldIsHalt;

  // A held instruction is taken by decode only when no redirect squashes it.
  assign decodeAccept = (state == HOLD) && if_ready && !redirect_valid;
  assign heldIsHalt   = isHaltInstr(if_instr[31:0]);

  // Next-state, next-PC and next-output decode for the fetch FSM.
  always_comb begin
    stateNext    = state;
    pcNext       = pc;
    reqValidNext = 1'b0;
    ifValidNext  = if_valid;
    haltedNext   = halted;
    loadInstr    = 1'b0;
    case (state)
      BOOT: begin
        stateNext    = REQ;
        reqValidNext = 1'b1;
      end
      REQ: begin
        if (redirect_valid) begin
          // Withdraw the request for a cycle and reissue at the new target.
          pcNext = redirect_pc;
        end else if (imem_req_valid && imem_req_ready) begin
          stateNext = WAIT;
        end else begin
          reqValidNext = 1'b1;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pcNext = redirect_pc;
          if (imem_rsp_valid) begin
            stateNext    = REQ;
            reqValidNext = 1'b1;
          end else begin
            stateNext = DRAIN;
          end
        end else if (imem_rsp_valid) begin
          loadInstr   = 1'b1;
          ifValidNext = 1'b1;
          stateNext   = HOLD;
        end
      end
      DRAIN: begin
        // Stale response still in flight; the latest redirect target wins.
        if (redirect_valid) begin
          pcNext = redirect_pc;
        end
        if (imem_rsp_valid) begin
          stateNext    = REQ;
          reqValidNext = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pcNext       = redirect_pc;
          ifValidNext  = 1'b0;
          stateNext    = REQ;
          reqValidNext = 1'b1;
        end else if (if_ready) begin
          pcNext      = if_pc + PC_WIDTH'(PC_STEP);
          ifValidNext = 1'b0;
          if (heldIsHalt) begin
            stateNext  = HALTED;
            haltedNext = 1'b1;
          end else begin
            stateNext    = REQ;
            reqValidNext = 1'b1;
          end
        end
      end
      HALTED: begin
        ifValidNext = 1'b0;
        haltedNext  = 1'b1;
      end
      default: begin
        stateNext = BOOT;
      end
    endcase
  end

  // State, PC and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= BOOT;
      pc             <= RESET_PC;
      imem_req_valid <= 1'b0;
      imem_addr      <= RESET_PC;
      if_valid       <= 1'b0;
      if_instr       <= '0;
      if_pc          <= '0;
      halted         <= 1'b0;
    end else begin
      state          <= stateNext;
      pc             <= pcNext;
      imem_req_valid <= reqValidNext;
      imem_addr      <= pcNext;
      if_valid       <= ifValidNext;
      halted         <= haltedNext;
      if (loadInstr) begin
        if_instr <= imem_rsp_data;
        if_pc    <= pc;
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating increment so the counter sticks at all-ones.
  function automatic logic [31:0] satInc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

  // Count instructions accepted by decode; naturally frozen once halted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (decodeAccept) begin
      fetch_count <= satInc(fetch_count);
    end
  end
`else
  logic unusedAccept;
  assign unusedAccept = decodeAccept;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed scenarios followed by randomized
// memory/decode/redirect traffic, checked against a transaction-level model.
module tb_instruction_fetch;

  localparam int          PW  = 64;
  localparam int          IW  = 32;
  localparam logic [63:0] RPC = 64'h0;

  logic          clk;
  logic          reset;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [PW-1:0] imem_addr;
  logic          imem_rsp_valid;
  logic [IW-1:0] imem_rsp_data;
  logic          if_valid;
  logic          if_ready;
  logic [IW-1:0] if_instr;
  logic [PW-1:0] if_pc;
  logic          redirect_valid;
  logic [PW-1:0] redirect_pc;
  logic          halted;
`ifdef FETCH_PERF_EN
  logic [31:0]   fetch_count;
`endif

  instruction_fetch #(
    .PC_WIDTH   (PW),
    .RESET_PC   (RPC),
    .INSTR_WIDTH(IW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halted        (halted)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count   (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // memory model state
  int          lat = 1;
  int          cnt = 0;
  logic [63:0] memAddr;
  logic        haltEn = 1'b0;
  logic [63:0] haltAddr = 64'h0;

  // transaction-level reference model
  logic        mHeld, mHalted, mLive;
  logic [63:0] mExpPc, mReqAddr, mHeldPc;
  int          mAccepts;
  int          sinceReset;
  int          cycleNo = 0;
  int          obsAccepts = 0;
  logic        lastAcc = 1'b0;
  logic [63:0] lastAccAddr;

  // scenario scratch
  int          rises;
  int          riseAt [3];
  logic        prevV;
  logic [63:0] pc0, heldPc;
  logic [31:0] in0;
  logic [63:0] accs [$];
  logic        sawValid;

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [63:0] a);
    if (haltEn && a == haltAddr) return 32'hFFE0_0000;
    return 32'h8B02_0020 ^ {8'h00, a[17:2], 8'h00};
  endfunction

  task automatic modelReset();
    mHeld = 0; mHalted = 0; mLive = 0;
    mExpPc = RPC; mReqAddr = RPC; mHeldPc = RPC;
    mAccepts = 0; sinceReset = 0;
  endtask

  task automatic checkReset(input string tag);
    checkEq({tag, "_req_valid"}, imem_req_valid, 0);
    checkEq({tag, "_addr"}, imem_addr, RPC);
    checkEq({tag, "_if_valid"}, if_valid, 0);
    checkEq({tag, "_if_instr"}, if_instr, 0);
    checkEq({tag, "_if_pc"}, if_pc, 0);
    checkEq({tag, "_halted"}, halted, 0);
  endtask

  // One clock: update the model from this cycle's traffic, advance, compare.
  task automatic tick();
    logic acc, rdr, rdy, rsp, stallHold;
    logic [63:0] addr, rpc;
    logic [31:0] w;
    acc = imem_req_valid && imem_req_ready;
    addr = imem_addr;
    rdr = redirect_valid; rpc = redirect_pc; rdy = if_ready; rsp = imem_rsp_valid;
    stallHold = imem_req_valid && !imem_req_ready && !redirect_valid && !reset;
    if (!reset) begin
      if (if_valid && if_ready && !redirect_valid) obsAccepts++;
      if (mHeld) begin
        if (rdr) mHeld = 0;
        else if (rdy) begin
          mHeld = 0;
          mAccepts++;
          mExpPc = mHeldPc + 64'd4;
          w = memWord(mHeldPc);
          if (w[31:21] == 11'h7FF) mHalted = 1;
        end
      end
      if (rdr && !mHalted) begin mExpPc = rpc; mLive = 0; end
      if (rsp && mLive && !rdr) begin mHeld = 1; mHeldPc = mReqAddr; mLive = 0; end
      if (acc) begin
        checkEq("req_addr", addr, mExpPc);
        mLive = 1; mReqAddr = addr;
      end
    end
    @(posedge clk);
    #1;
    cycleNo++;
    sinceReset++;
    lastAcc = acc;
    if (acc) lastAccAddr = addr;
    if (acc) begin cnt = lat; memAddr = addr; end
    imem_rsp_valid = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = memWord(memAddr);
      end
    end
    if (reset) checkReset("in_reset");
    else begin
      checkEq("if_valid", if_valid, mHeld);
      checkEq("halted", halted, mHalted);
      if (mHeld) begin
        checkEq("if_pc", if_pc, mHeldPc);
        checkEq("if_instr", if_instr, memWord(mHeldPc));
      end
      if (mHeld || mHalted) checkEq("no_req", imem_req_valid, 0);
      if (stallHold) begin
        checkEq("addr_stable", imem_addr, addr);
        checkEq("req_held", imem_req_valid, 1);
      end
`ifdef FETCH_PERF_EN
      checkEq("fetch_count", fetch_count, mAccepts);
`endif
    end
  endtask

  task automatic doReset(input int n);
    reset = 1'b1;
    #1;
    checkReset("async_reset");
    repeat (n) tick();
    reset = 1'b0;
    modelReset();
  endtask

  task automatic waitAcc(input string tag);
    int n;
    n = 0;
    do begin tick(); n++; end while (!lastAcc && n < 60);
    checkEq({tag, "_acc_seen"}, lastAcc, 1);
  endtask

  task automatic waitValid(input string tag);
    int n;
    n = 0;
    do begin tick(); n++; end while (!if_valid && n < 60);
    checkEq({tag, "_valid_seen"}, if_valid, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 0; reset = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
    if_ready = 0; redirect_valid = 0; redirect_pc = '0;
    modelReset();
    #2;
    // Zero-wait memory, decode always ready
    imem_req_ready = 1; if_ready = 1; lat = 1;
    doReset(3);
    tick();
    checkEq("first_req_valid", imem_req_valid, 1);
    checkEq("first_req_addr", imem_addr, RPC);
    rises = 0; riseAt = '{0, 0, 0}; prevV = if_valid; pc0 = '1; in0 = '0;
    for (int i = 0; i < 40 && rises < 3; i++) begin
      tick();
      if (lastAcc) accs.push_back(lastAccAddr);
      if (if_valid && !prevV) begin
        if (rises == 0) begin pc0 = if_pc; in0 = if_instr; end
        riseAt[rises] = cycleNo;
        rises++;
      end
      prevV = if_valid;
    end
    checkEq("t1_rises", rises, 3);
    checkEq("t1_pc0", pc0, 64'h0);
    checkEq("t1_instr0", in0, 32'h8B02_0020);
    checkEq("t1_gap01", riseAt[1] - riseAt[0], 3);
    checkEq("t1_gap12", riseAt[2] - riseAt[1], 3);
    if (accs.size() < 3) checkEq("t1_acc_count", accs.size(), 3);
    else begin
      checkEq("t1_acc0", accs[0], 64'h0);
      checkEq("t1_acc1", accs[1], 64'h4);
      checkEq("t1_acc2", accs[2], 64'h8);
    end

    // Decode stalls in HOLD
    if_ready = 0;
    waitValid("t2_hold");
    repeat (5) tick();
    heldPc = if_pc;
    if_ready = 1;
    waitAcc("t2_next");
    checkEq("t2_next_addr", lastAccAddr, heldPc + 64'd4);

    // Redirect while waiting; stale response arrives two cycles later
    lat = 3;
    waitAcc("t3_wait");
    redirect_valid = 1; redirect_pc = 64'h100;
    tick();
    redirect_valid = 0;
    sawValid = 0;
    for (int i = 0; i < 60 && !lastAcc; i++) begin
      tick();
      if (if_valid) sawValid = 1;
    end
    checkEq("t3_stale_dropped", sawValid, 0);
    checkEq("t3_redirect_addr", lastAccAddr, 64'h100);

    // Redirect beats decode-ready on a held HALT
    lat = 1;
    if_ready = 0;
    waitValid("t4_hold");
    haltEn = 1; haltAddr = 64'h200;
    redirect_valid = 1; redirect_pc = 64'h200;
    tick();
    redirect_valid = 0;
    waitValid("t4_halt_held");
    checkEq("t4_pc", if_pc, 64'h200);
    checkEq("t4_instr", if_instr, 32'hFFE0_0000);
    if_ready = 1; redirect_valid = 1; redirect_pc = 64'h300;
    tick();
    redirect_valid = 0;
    checkEq("t4_no_halt", halted, 0);
    waitAcc("t4_refetch");
    checkEq("t4_refetch_addr", lastAccAddr, 64'h300);
    haltEn = 0;

    // HALT at 0x10 after five accepts
    haltEn = 1; haltAddr = 64'h10;
    doReset(2);
    obsAccepts = 0;
    for (int i = 0; i < 60 && !halted; i++) tick();
    checkEq("t5_halted", halted, 1);
    checkEq("t5_accepts", obsAccepts, 5);
`ifdef FETCH_PERF_EN
    checkEq("t5_count", fetch_count, 5);
`endif
    for (int i = 0; i < 20; i++) begin
      redirect_valid = (i % 3 == 0); redirect_pc = 64'h40;
      tick();
      checkEq("t5_halt_noreq", imem_req_valid, 0);
    end
    redirect_valid = 0;
    checkEq("t5_still_halted", halted, 1);
    checkEq("t5_accepts_frozen", obsAccepts, 5);
`ifdef FETCH_PERF_EN
    checkEq("t5_count_frozen", fetch_count, 5);
`endif

    // Reset during WAIT; stale response lands right after release
    haltAddr = 64'h80;
    lat = 4;
    doReset(2);
    waitAcc("t6_first");
    waitAcc("t6_second");
    doReset(2);
    tick();
    checkEq("t6_req_valid", imem_req_valid, 1);
    checkEq("t6_req_addr", imem_addr, RPC);
    waitValid("t6_fresh");
    checkEq("t6_pc", if_pc, RPC);
    checkEq("t6_instr", if_instr, 32'h8B02_0020);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom % 4) != 0;
      if_ready = ($urandom % 3) != 0;
      lat = $urandom_range(1, 3);
      if (!imem_req_valid && sinceReset >= 2 && ($urandom % 8) == 0) begin
        redirect_valid = 1;
        case ($urandom % 4)
          0: redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
          1: redirect_pc = RPC;
          default: redirect_pc = 64'($urandom_range(0, 63)) * 64'd4;
        endcase
      end else begin
        redirect_valid = 0;
      end
      tick();
      if ((halted && ($urandom % 4) == 0) || ($urandom % 700) == 0) begin
        redirect_valid = 0;
        doReset($urandom_range(1, 3));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
